// File: rtl/joystick_adc.sv
// rtl/joystick_adc.sv - joystick ADC reader with 4-sample moving average and centre deadzone
//
// Purpose:
//   Periodically runs one conversion on an 8-bit serial ADC, keeps a running
//   sum over the last four bytes and publishes the truncated mean as the
//   paddle control value. Means inside the centre band snap to 0x80.
//
// Ports:
//   clk           in   system clock (only clock)
//   rst           in   synchronous active-high reset
//   adc_miso      in   ADC serial data, MSB first
//   adc_cs_n      out  ADC chip select, active-low, registered
//   adc_sclk      out  ADC serial clock, registered
//   control       out  filtered joystick value, 0x80 = neutral
//   control_valid out  one-cycle pulse when control is updated
//   raw_sample    out  last unfiltered ADC byte
module joystick_adc #(
  parameter int CLK_DIV       = 25,
  parameter int SAMPLE_PERIOD = 100000,
  parameter int DEADZONE      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       adc_miso,
  output logic       adc_cs_n,
  output logic       adc_sclk,
  output logic [7:0] control,
  output logic       control_valid,
  output logic [7:0] raw_sample
);

  localparam int PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int DW = $clog2(CLK_DIV + 1);

  localparam logic [PW-1:0] PERIOD_LAST = PW'(SAMPLE_PERIOD - 1);
  localparam logic [DW-1:0] DIV_LAST    = DW'(CLK_DIV - 1);
  localparam logic [7:0]    DZ_LO       = 8'(128 - DEADZONE);
  localparam logic [7:0]    DZ_HI       = 8'(128 + DEADZONE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_DONE,
    S_FILTER
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     period_q, period_d;
  logic [DW-1:0]     div_q, div_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              cs_n_q, cs_n_d;
  logic              sclk_q, sclk_d;
  logic [7:0]        raw_q, raw_d;
  logic [3:0][7:0]   hist_q, hist_d;
  logic [9:0]        sum_q, sum_d;
  logic [7:0]        control_q, control_d;
  logic              valid_q, valid_d;

  logic              wrap;
  logic              div_last;
  logic [7:0]        avg;

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    cs_n_d    = cs_n_q;
    sclk_d    = sclk_q;
    raw_d     = raw_q;
    hist_d    = hist_q;
    sum_d     = sum_q;
    control_d = control_q;
    valid_d   = 1'b0;

    wrap     = (period_q == PERIOD_LAST);
    div_last = (div_q == DIV_LAST);
    avg      = sum_q[9:2];
    period_d = wrap ? '0 : period_q + 1'b1;

    // Registered outputs are loaded on the edge that enters a state, so each
    // state's outputs are valid for exactly the cycles spent in it.
    unique case (state_q)
      S_IDLE: begin
        // A wrap outside IDLE is simply ignored.
        if (wrap) begin
          state_d = S_SETUP;
          cs_n_d  = 1'b0;
          div_d   = '0;
        end
      end

      S_SETUP: begin
        if (div_last) begin
          state_d = S_SHIFT;
          div_d   = '0;
          bit_d   = 3'd7;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      S_SHIFT: begin
        if (div_last) begin
          div_d = '0;
          if (!sclk_q) begin
            // Rising sclk edge: capture the bit the ADC has been holding.
            sclk_d  = 1'b1;
            shift_d = {shift_q[6:0], adc_miso};
          end else begin
            sclk_d = 1'b0;
            if (bit_q == 3'd0) begin
              state_d = S_DONE;
              cs_n_d  = 1'b1;
              raw_d   = shift_q;
              hist_d  = {hist_q[2:0], shift_q};
              // Incremental update; the exact sum fits in 10 bits so the
              // modular add/subtract never loses information.
              sum_d   = sum_q + {2'b00, shift_q} - {2'b00, hist_q[3]};
            end else begin
              bit_d = bit_q - 1'b1;
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d   = S_FILTER;
        valid_d   = 1'b1;
        control_d = ((avg >= DZ_LO) && (avg <= DZ_HI)) ? 8'h80 : avg;
      end

      S_FILTER: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      period_q  <= '0;
      div_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b0;
      raw_q     <= 8'h80;
      hist_q    <= {4{8'h80}};
      sum_q     <= 10'd512;
      control_q <= 8'h80;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      cs_n_q    <= cs_n_d;
      sclk_q    <= sclk_d;
      raw_q     <= raw_d;
      hist_q    <= hist_d;
      sum_q     <= sum_d;
      control_q <= control_d;
      valid_q   <= valid_d;
    end
  end

  assign adc_cs_n      = cs_n_q;
  assign adc_sclk      = sclk_q;
  assign control       = control_q;
  assign control_valid = valid_q;
  assign raw_sample    = raw_q;

endmodule

// File: tb/tb_joystick_adc.sv
// tb/tb_joystick_adc.sv - directed self-checking bench for joystick_adc
module tb_joystick_adc;

  localparam int CLK_DIV       = 2;
  localparam int SAMPLE_PERIOD = 64;
  localparam int DEADZONE      = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       adc_miso = 1'b0;
  logic       adc_cs_n;
  logic       adc_sclk;
  logic [7:0] control;
  logic       control_valid;
  logic [7:0] raw_sample;

  joystick_adc #(
    .CLK_DIV      (CLK_DIV),
    .SAMPLE_PERIOD(SAMPLE_PERIOD),
    .DEADZONE     (DEADZONE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .adc_miso     (adc_miso),
    .adc_cs_n     (adc_cs_n),
    .adc_sclk     (adc_sclk),
    .control      (control),
    .control_valid(control_valid),
    .raw_sample   (raw_sample)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;
  int last_fall   = 0;

  // ADC model: presents adc_byte MSB first, next bit after each sclk fall.
  logic [7:0] adc_byte  = 8'h00;
  int         bit_idx   = 7;
  logic       sclk_prev = 1'b0;
  always @(negedge clk) begin
    if (adc_cs_n) bit_idx = 7;
    else if (sclk_prev && !adc_sclk && bit_idx > 0) bit_idx = bit_idx - 1;
    sclk_prev = adc_sclk;
    adc_miso  = adc_byte[bit_idx];
  end

  // Runs one conversion with byte b and reports what was observed.
  task automatic do_conversion(input logic [7:0] b, output int gap, output int low,
                               output int rises, output logic [7:0] raw, output int vdelay,
                               output int vwidth, output logic [7:0] ctrl, output int stray,
                               output int early_change);
    int fall;
    int n;
    logic [7:0] ctrl0;
    logic prev;
    adc_byte = b;
    gap = -1; low = -1; rises = 0; raw = 8'h00; vdelay = -1; vwidth = 0;
    ctrl = 8'h00; stray = 0; early_change = 0;
    n = 0;
    @(negedge clk);
    while (adc_cs_n && n < 200) begin
      if (control_valid) stray++;
      @(negedge clk);
      n++;
    end
    if (adc_cs_n) return;
    fall = cyc;
    gap = fall - last_fall;
    last_fall = fall;
    ctrl0 = control;
    prev = adc_sclk;
    n = 0;
    while (!adc_cs_n && n < 200) begin
      if (adc_sclk && !prev) rises++;
      prev = adc_sclk;
      if (control !== ctrl0) early_change = 1;
      @(negedge clk);
      n++;
    end
    low = cyc - fall;
    raw = raw_sample;
    n = 0;
    while (!control_valid && n < 10) begin
      if (control !== ctrl0) early_change = 1;
      @(negedge clk);
      n++;
    end
    if (!control_valid) return;
    vdelay = cyc - fall;
    ctrl = control;
    while (control_valid && vwidth < 10) begin
      vwidth++;
      @(negedge clk);
    end
    if (control !== ctrl) early_change = 1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (adc_cs_n !== 1'b1) begin miscompares++; $display("FAIL reset_cs_n: got %b expected 1", adc_cs_n); end
    vectors++; if (adc_sclk !== 1'b0) begin miscompares++; $display("FAIL reset_sclk: got %b expected 0", adc_sclk); end
    vectors++; if (control !== 8'h80) begin miscompares++; $display("FAIL reset_control: got %h expected 80", control); end
    vectors++; if (raw_sample !== 8'h80) begin miscompares++; $display("FAIL reset_raw: got %h expected 80", raw_sample); end
    vectors++; if (control_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", control_valid); end
    rst = 1'b0;
    last_fall = cyc;
  endtask

  task automatic test_single_frame();
    int gap, low, rises, vdelay, vwidth, stray, early;
    logic [7:0] raw, ctrl;
    do_conversion(8'hC3, gap, low, rises, raw, vdelay, vwidth, ctrl, stray, early);
    vectors++; if (gap !== 64) begin miscompares++; $display("FAIL first_fall_delay: got %0d expected 64", gap); end
    vectors++; if (low !== 34) begin miscompares++; $display("FAIL cs_low_cycles: got %0d expected 34", low); end
    vectors++; if (rises !== 8) begin miscompares++; $display("FAIL sclk_rises: got %0d expected 8", rises); end
    vectors++; if (raw !== 8'hC3) begin miscompares++; $display("FAIL single_raw: got %h expected c3", raw); end
    vectors++; if (vdelay !== 35) begin miscompares++; $display("FAIL valid_delay: got %0d expected 35", vdelay); end
    vectors++; if (vwidth !== 1) begin miscompares++; $display("FAIL valid_width: got %0d expected 1", vwidth); end
    vectors++; if (ctrl !== 8'h90) begin miscompares++; $display("FAIL single_control: got %h expected 90", ctrl); end
    vectors++; if (stray !== 0) begin miscompares++; $display("FAIL stray_valid: got %0d expected 0", stray); end
    vectors++; if (early !== 0) begin miscompares++; $display("FAIL control_unstable: got %0d expected 0", early); end
  endtask

  task automatic test_step_settling();
    logic [7:0] exp_c [3] = '{8'hA1, 8'hB2, 8'hC3};
    int gap, low, rises, vdelay, vwidth, stray, early;
    logic [7:0] raw, ctrl;
    for (int i = 0; i < 3; i++) begin
      do_conversion(8'hC3, gap, low, rises, raw, vdelay, vwidth, ctrl, stray, early);
      vectors++; if (gap !== 64) begin miscompares++; $display("FAIL step_period[%0d]: got %0d expected 64", i, gap); end
      vectors++; if (ctrl !== exp_c[i]) begin miscompares++; $display("FAIL step_control[%0d]: got %h expected %h", i, ctrl, exp_c[i]); end
      vectors++; if (vwidth !== 1) begin miscompares++; $display("FAIL step_valid_width[%0d]: got %0d expected 1", i, vwidth); end
    end
  endtask

  task automatic test_deadzone();
    logic [7:0] din   [12] = '{8'h88, 8'h88, 8'h88, 8'h88, 8'h89, 8'h89, 8'h89, 8'h89,
                               8'h77, 8'h77, 8'h77, 8'h77};
    logic [7:0] exp_c [12] = '{8'hB4, 8'hA5, 8'h96, 8'h80, 8'h80, 8'h80, 8'h80, 8'h89,
                               8'h80, 8'h80, 8'h80, 8'h77};
    int gap, low, rises, vdelay, vwidth, stray, early;
    logic [7:0] raw, ctrl;
    for (int i = 0; i < 12; i++) begin
      do_conversion(din[i], gap, low, rises, raw, vdelay, vwidth, ctrl, stray, early);
      vectors++; if (ctrl !== exp_c[i]) begin miscompares++; $display("FAIL deadzone_control[%0d]: got %h expected %h", i, ctrl, exp_c[i]); end
      vectors++; if (raw !== din[i]) begin miscompares++; $display("FAIL deadzone_raw[%0d]: got %h expected %h", i, raw, din[i]); end
    end
  endtask

  task automatic test_extremes();
    logic [7:0] din   [8] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] exp_c [8] = '{8'h99, 8'hBB, 8'hDD, 8'hFF, 8'hBF, 8'h80, 8'h3F, 8'h00};
    int gap, low, rises, vdelay, vwidth, stray, early;
    logic [7:0] raw, ctrl;
    for (int i = 0; i < 8; i++) begin
      do_conversion(din[i], gap, low, rises, raw, vdelay, vwidth, ctrl, stray, early);
      vectors++; if (ctrl !== exp_c[i]) begin miscompares++; $display("FAIL extreme_control[%0d]: got %h expected %h", i, ctrl, exp_c[i]); end
      vectors++; if (raw !== din[i]) begin miscompares++; $display("FAIL extreme_raw[%0d]: got %h expected %h", i, raw, din[i]); end
    end
  endtask

  task automatic test_reset_mid_shift();
    int n, r;
    logic prev;
    int gap, low, rises, vdelay, vwidth, stray, early;
    logic [7:0] raw, ctrl;
    adc_byte = 8'h5A;
    n = 0;
    @(negedge clk);
    while (adc_cs_n && n < 200) begin @(negedge clk); n++; end
    r = 0;
    prev = adc_sclk;
    while (r < 3 && n < 400) begin
      @(negedge clk);
      if (adc_sclk && !prev) r++;
      prev = adc_sclk;
      n++;
    end
    vectors++; if (r !== 3) begin miscompares++; $display("FAIL midshift_reach_3rd_rise: got %0d expected 3", r); end
    rst = 1'b1;
    @(negedge clk);
    vectors++; if (adc_cs_n !== 1'b1) begin miscompares++; $display("FAIL midshift_cs_n: got %b expected 1", adc_cs_n); end
    vectors++; if (adc_sclk !== 1'b0) begin miscompares++; $display("FAIL midshift_sclk: got %b expected 0", adc_sclk); end
    vectors++; if (control !== 8'h80) begin miscompares++; $display("FAIL midshift_control: got %h expected 80", control); end
    vectors++; if (raw_sample !== 8'h80) begin miscompares++; $display("FAIL midshift_raw: got %h expected 80", raw_sample); end
    vectors++; if (control_valid !== 1'b0) begin miscompares++; $display("FAIL midshift_valid: got %b expected 0", control_valid); end
    rst = 1'b0;
    last_fall = cyc;
    do_conversion(8'h5A, gap, low, rises, raw, vdelay, vwidth, ctrl, stray, early);
    vectors++; if (gap !== 64) begin miscompares++; $display("FAIL post_reset_fall_delay: got %0d expected 64", gap); end
    vectors++; if (stray !== 0) begin miscompares++; $display("FAIL post_reset_stray_valid: got %0d expected 0", stray); end
    vectors++; if (rises !== 8) begin miscompares++; $display("FAIL post_reset_rises: got %0d expected 8", rises); end
    vectors++; if (raw !== 8'h5A) begin miscompares++; $display("FAIL post_reset_raw: got %h expected 5a", raw); end
    vectors++; if (ctrl !== 8'h76) begin miscompares++; $display("FAIL post_reset_control: got %h expected 76", ctrl); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_frame();
    test_step_settling();
    test_deadzone();
    test_extremes();
    test_reset_mid_shift();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
